fifo_rd_stream: RTL

Read-side controller for the team's single-clock FIFO in non-showahead mode, with 1-cycle read latency. It drains words from the FIFO read port and presents them on a valid/ready stream with packet framing. A 2-entry output buffer with read credit sustains one word per cycle under backpressure. It sits between a `fifo` instance and downstream stream consumers.

---
 rtl/fifo_rd_stream.sv | 90 +++++++++
 1 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a 1-cycle-latency FIFO read port into a
// valid/ready packet stream through a 2-entry buffer with read credit.
// Ports:
//   clk_i, arst_n_i        clock, async active-low reset
//   empty_i, q_i, rdreq_o  FIFO read port (non-showahead)
//   data_o, valid_o, ready_i            stream handshake
//   startofpacket_o, endofpacket_o      packet framing
//   pkt_cnt_o                           completed packets (wraps)
module fifo_rd_stream #(
  parameter int DWIDTH  = 16,
  parameter int PKT_LEN = 8,
  parameter int CNTW    = 16
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              empty_i,
  input  logic [DWIDTH-1:0] q_i,
  output logic              rdreq_o,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              startofpacket_o,
  output logic              endofpacket_o,
  output logic [CNTW-1:0]   pkt_cnt_o
);

  localparam int WCW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [WCW-1:0] LAST = WCW'(PKT_LEN - 1);

  logic [1:0]        occ_q, occ_d;
  logic              rd_pend_q;
  logic [DWIDTH-1:0] head_q, head_d;
  logic [DWIDTH-1:0] skid_q, skid_d;
  logic [WCW-1:0]    wcnt_q, wcnt_d;
  logic [CNTW-1:0]   pcnt_q, pcnt_d;
  logic              pop;
  logic [2:0]        credit;

  assign valid_o = (occ_q != 2'd0);
  assign pop     = valid_o & ready_i;

  // words held or in flight once this cycle's pop retires
  assign credit = {1'b0, occ_q} + {2'b0, rd_pend_q}
                - {2'b0, pop};

  assign rdreq_o = arst_n_i & ~empty_i & (credit < 3'd2);

  assign data_o          = head_q;
  assign startofpacket_o = (wcnt_q == '0);
  assign endofpacket_o   = (wcnt_q == LAST);
  assign pkt_cnt_o       = pcnt_q;

  always_comb begin
    occ_d  = credit[1:0];
    head_d = head_q;
    skid_d = skid_q;
    wcnt_d = wcnt_q;
    pcnt_d = pcnt_q;
    if (pop && occ_q == 2'd2) head_d = skid_q;
    if (rd_pend_q) begin
      if (occ_q == 2'd0 || (occ_q == 2'd1 && pop))
        head_d = q_i;
      else
        skid_d = q_i;
    end
    if (pop) begin
      wcnt_d = (wcnt_q == LAST) ? '0 : wcnt_q + 1'b1;
      if (endofpacket_o) pcnt_d = pcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      occ_q     <= '0;
      rd_pend_q <= 1'b0;
      head_q    <= '0;
      skid_q    <= '0;
      wcnt_q    <= '0;
      pcnt_q    <= '0;
    end else begin
      occ_q     <= occ_d;
      rd_pend_q <= rdreq_o;
      head_q    <= head_d;
      skid_q    <= skid_d;
      wcnt_q    <= wcnt_d;
      pcnt_q    <= pcnt_d;
    end
  end

endmodule
